quire_window_arbiter: RTL

//  Shares one quire_4_0 accumulator between NB_REQ decoded-product streams.

---
 rtl/quire_window_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/quire_window_arbiter.sv
// quire_window_arbiter
// Shares one quire accumulator between NB_REQ decoded-product streams. A lane
// owns the quire for a whole accumulation window (sow..eow). Window starts are
// arbitrated round-robin. Granted beats pass through a one-entry output slice
// with an rts/rtr handshake. Window length is capped at 2**LOG_NB_ACCUM beats
// so the quire's overflow headroom is never exceeded.
//
// state | meaning
// IDLE  | arbitrate lanes offering sow; drain orphan (non-sow) beats when none do
// LOCK  | owner lane streams its window into the output slice until eow or cap

module quire_window_arbiter #(
  parameter int NB_REQ       = 4,
  parameter int LOG_NB_ACCUM = 10,
  parameter int IDX_W        = $clog2(NB_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NB_REQ-1:0]   rts_i,
  output logic [NB_REQ-1:0]   rtr_o,
  input  logic [NB_REQ-1:0]   sow_i,
  input  logic [NB_REQ-1:0]   eow_i,
  input  logic [4*NB_REQ-1:0] fraction_i,
  input  logic [4*NB_REQ-1:0] scale_i,
  input  logic [NB_REQ-1:0]   sign_i,
  input  logic [NB_REQ-1:0]   zero_i,
  input  logic [NB_REQ-1:0]   NaR_i,
  input  logic                rtr_i,
  output logic                rts_o,
  output logic                sow_o,
  output logic                eow_o,
  output logic [3:0]          fraction_o,
  output logic [3:0]          scale_o,
  output logic                sign_o,
  output logic                zero_o,
  output logic                NaR_o,
  output logic [IDX_W-1:0]    owner_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int CNT_W = LOG_NB_ACCUM + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((2 ** LOG_NB_ACCUM) - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic [NB_REQ-1:0] cand;
  logic [NB_REQ-1:0] orphan;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  lane_idx;
  logic              win_valid;

  logic [NB_REQ-1:0] own_sel;
  logic              own_rts;
  logic              own_eow;
  logic [3:0]        own_frac;
  logic [3:0]        own_scale;
  logic              own_sign;
  logic              own_zero;
  logic              own_nar;

  logic              slice_free;
  logic              accept;
  logic              forced;
  logic              err_d;

  assign cand       = rts_i & sow_i;
  assign orphan     = rts_i & ~sow_i;
  assign slice_free = ~rts_o | rtr_i;

  assign owner_o = owner_q;
  assign busy_o  = (state_q == LOCK);

  // Round-robin winner: first sow candidate at or after rr_ptr, wrapping.
  always_comb begin
    winner    = '0;
    win_valid = 1'b0;
    lane_idx  = '0;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      lane_idx = IDX_W'((int'(rr_ptr_q) + i) % NB_REQ);
      if (cand[lane_idx]) begin
        win_valid = 1'b1;
        winner    = lane_idx;
      end
    end
  end

  // Mux out the owning lane's handshake, framing and payload.
  always_comb begin
    own_sel   = '0;
    own_rts   = 1'b0;
    own_eow   = 1'b0;
    own_frac  = '0;
    own_scale = '0;
    own_sign  = 1'b0;
    own_zero  = 1'b0;
    own_nar   = 1'b0;
    for (int k = 0; k < NB_REQ; k++) begin
      if (owner_q == IDX_W'(k)) begin
        own_sel[k] = 1'b1;
        own_rts    = rts_i[k];
        own_eow    = eow_i[k];
        own_frac   = fraction_i[4*k +: 4];
        own_scale  = scale_i[4*k +: 4];
        own_sign   = sign_i[k];
        own_zero   = zero_i[k];
        own_nar    = NaR_i[k];
      end
    end
  end

  // Next-state, lane ready and error decode.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    rtr_o      = '0;
    accept     = 1'b0;
    forced     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // The grant cycle itself accepts nothing; the window starts in LOCK.
        if (win_valid) begin
          owner_d    = winner;
          beat_cnt_d = '0;
          state_d    = LOCK;
        end else if (|orphan) begin
          rtr_o = orphan;
          err_d = 1'b1;
        end
      end

      LOCK: begin
        rtr_o  = own_sel & {NB_REQ{slice_free}};
        accept = own_rts & slice_free;
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          forced     = (beat_cnt_q == LAST_CNT) & ~own_eow;
          err_d      = forced;
          if (own_eow | forced) begin
            state_d  = IDLE;
            rr_ptr_d = (owner_q == IDX_W'(NB_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Nothing is consumed from the lanes while reset is held.
    if (rst) begin
      rtr_o  = '0;
      accept = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      err_o      <= err_d;
    end
  end

  // One-entry output slice: load on accept, hold under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      rts_o      <= 1'b0;
      sow_o      <= 1'b0;
      eow_o      <= 1'b0;
      fraction_o <= '0;
      scale_o    <= '0;
      sign_o     <= 1'b0;
      zero_o     <= 1'b0;
      NaR_o      <= 1'b0;
    end else if (accept) begin
      rts_o      <= 1'b1;
      sow_o      <= (beat_cnt_q == '0);
      eow_o      <= own_eow | forced;
      fraction_o <= own_frac;
      scale_o    <= own_scale;
      sign_o     <= own_sign;
      zero_o     <= own_zero;
      NaR_o      <= own_nar;
    end else if (rtr_i) begin
      rts_o <= 1'b0;
    end
  end

endmodule
